// File: rtl/bram_tx_reader_pkg.sv
// Shared types and sizing helpers for the transmit BRAM reader.
// Byte order is selected by BRAM_TX_MSB_FIRST_EN (see word_byte_serializer).
package bram_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND,
        DONE
    } state_t;

    function automatic int bytes_per(input int width_data);
        return width_data / 8;
    endfunction

    // Index width never drops below 1 so single-byte words still elaborate.
    function automatic int idx_w(input int width_data);
        return (width_data <= 16) ? 1 : $clog2(width_data / 8);
    endfunction

    localparam int BYTES_PER_WORD = bytes_per(256);
    localparam int BYTE_IDX_W     = idx_w(256);

endpackage

// File: rtl/bram_tx_reader_if.sv
// Control, BRAM read port and UART TX byte stream bundle of the reader.
// master = reader side, slave = surrounding system (BRAM, UART, controller).
interface bram_tx_if #(
    parameter int WIDTH_DATA = 256,
    parameter int WIDTH_ADDR = 10
);
    logic                  i_start;
    logic [WIDTH_ADDR-1:0] i_base_addr;
    logic [WIDTH_ADDR:0]   i_num_words;
    logic                  o_rd_en;
    logic [WIDTH_ADDR-1:0] o_raddr;
    logic [WIDTH_DATA-1:0] i_rdata;
    logic [7:0]            o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;
    logic                  o_busy;
    logic                  o_done;

    modport master (
        input  i_start, i_base_addr, i_num_words, i_rdata, i_tx_ready,
        output o_rd_en, o_raddr, o_tx_data, o_tx_valid, o_busy, o_done
    );

    modport slave (
        output i_start, i_base_addr, i_num_words, i_rdata, i_tx_ready,
        input  o_rd_en, o_raddr, o_tx_data, o_tx_valid, o_busy, o_done
    );
endinterface

// File: rtl/word_byte_serializer.sv
// Load-and-shift register that presents one byte of a BRAM word at a time.
// BRAM_TX_MSB_FIRST_EN defined: MSB byte first; otherwise LSB byte first.
module word_byte_serializer #(
    parameter int WIDTH_DATA = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic [WIDTH_DATA-1:0] word,
    output logic [7:0]            data_out
);

    logic [WIDTH_DATA-1:0] sreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= word;
        end else if (shift) begin
`ifdef BRAM_TX_MSB_FIRST_EN
            sreg <= {sreg[WIDTH_DATA-9:0], 8'h00};
`else
            sreg <= {8'h00, sreg[WIDTH_DATA-1:8]};
`endif
        end
    end

`ifdef BRAM_TX_MSB_FIRST_EN
    assign data_out = sreg[WIDTH_DATA-1 -: 8];
`else
    assign data_out = sreg[7:0];
`endif

endmodule

// File: rtl/bram_tx_reader.sv
// Fetches a run of BRAM words and streams their bytes to the UART TX.
// Byte order within a word follows BRAM_TX_MSB_FIRST_EN.
module bram_tx_reader
    import bram_tx_pkg::*;
#(
    parameter int WIDTH_DATA = 256,
    parameter int WIDTH_ADDR = 10
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    bram_tx_if.master bus
);

    localparam int NBYTES = bytes_per(WIDTH_DATA);
    localparam int IDX_W  = idx_w(WIDTH_DATA);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [WIDTH_ADDR-1:0] addr;
    logic [WIDTH_ADDR-1:0] addr_nxt;
    logic [WIDTH_ADDR:0]   words;
    logic [WIDTH_ADDR:0]   words_nxt;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic                  load;
    logic                  shift;
    logic                  hs;

    assign hs = bus.o_tx_valid && bus.i_tx_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            addr  <= '0;
            words <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            words <= words_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        words_nxt = words;
        idx_nxt   = idx;
        load      = 1'b0;
        shift     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.i_start) begin
                    addr_nxt  = bus.i_base_addr;
                    words_nxt = bus.i_num_words;
                    state_nxt = (bus.i_num_words == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_nxt = LATCH;
            LATCH: begin
                load      = 1'b1;
                idx_nxt   = '0;
                state_nxt = SEND;
            end
            SEND: begin
                if (hs) begin
                    if (idx == LAST_IDX) begin
                        // Address wraps naturally at the top of the BRAM.
                        words_nxt = words - 1'b1;
                        addr_nxt  = addr + 1'b1;
                        state_nxt = (words != 1) ? FETCH : DONE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                        shift   = 1'b1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_rd_en    <= 1'b0;
            bus.o_raddr    <= '0;
            bus.o_tx_valid <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_done     <= 1'b0;
        end else begin
            bus.o_rd_en    <= (state_nxt == FETCH);
            bus.o_tx_valid <= (state_nxt == SEND);
            bus.o_busy     <= (state_nxt != IDLE);
            bus.o_done     <= (state_nxt == DONE);
            if (state_nxt == FETCH) begin
                bus.o_raddr <= addr_nxt;
            end
        end
    end

    word_byte_serializer #(
        .WIDTH_DATA(WIDTH_DATA)
    ) u_ser (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .load    (load),
        .shift   (shift),
        .word    (bus.i_rdata),
        .data_out(bus.o_tx_data)
    );

endmodule

// File: tb/tb_bram_tx_reader.sv
// Directed bench for bram_tx_reader with a BRAM model and byte scoreboard.
// Honours BRAM_TX_MSB_FIRST_EN for the expected byte order.
module tb_bram_tx_reader;
    import bram_tx_pkg::*;

    localparam int WD = 256;
    localparam int WA = 10;
    localparam int NB = BYTES_PER_WORD;

    logic clk;
    logic rst_n;

    bram_tx_if #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA)) bus ();

    bram_tx_reader #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    logic [WD-1:0] mem [1024];
    logic [7:0]    byte_q [$];
    int            addr_q [$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            done_cnt = 0;
    bit            stall_prev = 0;
    logic [7:0]    stall_data = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.o_rd_en) bus.i_rdata <= mem[bus.o_raddr];
    end

    function automatic logic [7:0] mem_byte(input int a, input int k);
        return 8'(k ^ ((a - 5) * 37));
    endfunction

    function automatic int emit_idx(input int j);
`ifdef BRAM_TX_MSB_FIRST_EN
        return NB - 1 - j;
`else
        return j;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: read addresses, accepted bytes, stall stability, done pulses.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (bus.o_rd_en) begin
                chk("read_expected", 32'(addr_q.size() != 0), 1);
                if (addr_q.size() != 0)
                    chk("raddr", 32'(bus.o_raddr), 32'(addr_q.pop_front()));
            end
            if (stall_prev) begin
                chk("stall_valid", 32'(bus.o_tx_valid), 1);
                chk("stall_data", 32'(bus.o_tx_data), 32'(stall_data));
            end
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                chk("byte_expected", 32'(byte_q.size() != 0), 1);
                if (byte_q.size() != 0)
                    chk("tx_data", 32'(bus.o_tx_data), 32'(byte_q.pop_front()));
            end
            stall_prev = bus.o_tx_valid && !bus.i_tx_ready;
            stall_data = bus.o_tx_data;
            if (bus.o_done) done_cnt++;
        end
    end

    task automatic push_run(input int base, input int num);
        for (int w = 0; w < num; w++) begin
            int a;
            a = (base + w) % 1024;
            addr_q.push_back(a);
            for (int j = 0; j < NB; j++)
                byte_q.push_back(mem_byte(a, emit_idx(j)));
        end
    endtask

    task automatic start_run(input int base, input int num, input bit expect_it);
        if (expect_it) push_run(base, num);
        bus.i_start     = 1'b1;
        bus.i_base_addr = WA'(base);
        bus.i_num_words = (WA + 1)'(num);
        @(posedge clk);
        #1 bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input int inj, input bit rnd);
        int n;
        bit seen;
        int snap;
        n = 0;
        seen = 0;
        snap = done_cnt;
        while (!seen && n < 2000) begin
            @(negedge clk);
            n++;
            if (bus.o_done) begin
                seen = 1;
            end else begin
                @(posedge clk);
                #1;
                bus.i_start = (n == inj);
                if (n == inj) begin
                    bus.i_base_addr = 10'h100;
                    bus.i_num_words = 11'd5;
                end
                if (rnd) bus.i_tx_ready = 1'($urandom_range(0, 1));
            end
        end
        chk("done_seen", 32'(seen), 1);
        if (exp_cyc > 0) chk("done_cycle", n, exp_cyc);
        chk("busy_at_done", 32'(bus.o_busy), 1);
        @(negedge clk);
        chk("done_pulse", 32'(bus.o_done), 0);
        chk("busy_fall", 32'(bus.o_busy), 0);
        chk("done_count", done_cnt - snap, 1);
        chk("bytes_left", byte_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
        bus.i_tx_ready = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(bus.o_rd_en), 0);
        chk({tag, "_raddr"}, 32'(bus.o_raddr), 0);
        chk({tag, "_tx_data"}, 32'(bus.o_tx_data), 0);
        chk({tag, "_tx_valid"}, 32'(bus.o_tx_valid), 0);
        chk({tag, "_busy"}, 32'(bus.o_busy), 0);
        chk({tag, "_done"}, 32'(bus.o_done), 0);
    endtask

    initial begin
        int snap;
        for (int a = 0; a < 1024; a++)
            for (int k = 0; k < NB; k++)
                mem[a][8*k +: 8] = mem_byte(a, k);
        rst_n           = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_base_addr = '0;
        bus.i_num_words = '0;
        bus.i_rdata     = '0;
        bus.i_tx_ready  = 1'b1;
        chk("idx_width", BYTE_IDX_W, 5);

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Single word, timing of first read and first byte.
        start_run(5, 1, 1);
        @(negedge clk);
        chk("t1_rd_en", 32'(bus.o_rd_en), 1);
        chk("t1_raddr", 32'(bus.o_raddr), 5);
        @(negedge clk);
        chk("t2_valid", 32'(bus.o_tx_valid), 0);
        @(negedge clk);
        chk("t3_valid", 32'(bus.o_tx_valid), 1);
        wait_done(35 - 3, 0, 0);

        // Back-to-back multi-word run across the address wrap.
        start_run(10'h3FE, 3, 1);
        wait_done(103, 0, 0);

        // Zero count.
        start_run(10'h123, 0, 1);
        @(negedge clk);
        chk("zero_done", 32'(bus.o_done), 1);
        chk("zero_busy", 32'(bus.o_busy), 1);
        chk("zero_rd_en", 32'(bus.o_rd_en), 0);
        @(negedge clk);
        chk("zero_done_fall", 32'(bus.o_done), 0);
        chk("zero_busy_fall", 32'(bus.o_busy), 0);

        // Start while busy must be ignored.
        start_run(10'h010, 2, 1);
        wait_done(69, 10, 0);

        // Random backpressure.
        start_run(10'h200, 3, 1);
        wait_done(0, 0, 1);

        // Reset during SEND.
        start_run(10'h040, 2, 1);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_outputs_zero("midreset");
        byte_q.delete();
        addr_q.delete();
        snap = done_cnt;
        repeat (3) @(negedge clk);
        chk("midreset_no_done", done_cnt - snap, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        start_run(10'h3FF, 1, 1);
        wait_done(35, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
